// File: rtl/vx_writeback_arbiter_if.sv
// Commit-side and writeback-side signal bundle for vx_writeback_arbiter.
// The arbiter uses the slave modport; execute units and the issue stage use master.
interface vx_writeback_arbiter_if #(
  parameter int NUM_REQS    = 7,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int CNT_W       = $clog2(NUM_REQS * NUM_THREADS + 1)
);
  logic [NUM_REQS-1:0]                req_valid;
  logic [NUM_REQS-1:0]                req_wb;
  logic [NUM_REQS*NW_BITS-1:0]        req_wid;
  logic [NUM_REQS*NUM_THREADS-1:0]    req_tmask;
  logic [NUM_REQS*32-1:0]             req_pc;
  logic [NUM_REQS*NR_BITS-1:0]        req_rd;
  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data;
  logic [NUM_REQS-1:0]                req_eop;
  logic [NUM_REQS-1:0]                req_ready;

  logic                               wb_valid;
  logic [NW_BITS-1:0]                 wb_wid;
  logic [NUM_THREADS-1:0]             wb_tmask;
  logic [31:0]                        wb_pc;
  logic [NR_BITS-1:0]                 wb_rd;
  logic [NUM_THREADS*32-1:0]          wb_data;
  logic                               wb_eop;
  logic                               wb_ready;

  logic                               cmt_valid;
  logic [CNT_W-1:0]                   cmt_count;

  modport master (
    output req_valid, req_wb, req_wid, req_tmask, req_pc, req_rd, req_data, req_eop,
    input  req_ready,
    input  wb_valid, wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop,
    output wb_ready,
    input  cmt_valid, cmt_count
  );

  modport slave (
    input  req_valid, req_wb, req_wid, req_tmask, req_pc, req_rd, req_data, req_eop,
    output req_ready,
    output wb_valid, wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop,
    input  wb_ready,
    output cmt_valid, cmt_count
  );
endinterface

// File: rtl/vx_writeback_arbiter.sv
// Round-robin arbiter of per-unit commit streams onto the single register-file
// writeback port, with packet locking and a registered committed-thread count.
module vx_writeback_arbiter #(
  parameter int NUM_REQS    = 7,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int CNT_W       = $clog2(NUM_REQS * NUM_THREADS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_writeback_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int DW    = NUM_THREADS * 32;

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_e;

  lock_state_e            state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       lock_src_q, lock_src_d;

  logic                   wb_valid_q, wb_valid_d;
  logic [NW_BITS-1:0]     wb_wid_q, wb_wid_d;
  logic [NUM_THREADS-1:0] wb_tmask_q, wb_tmask_d;
  logic [31:0]            wb_pc_q, wb_pc_d;
  logic [NR_BITS-1:0]     wb_rd_q, wb_rd_d;
  logic [DW-1:0]          wb_data_q, wb_data_d;
  logic                   wb_eop_q, wb_eop_d;
  logic                   cmt_valid_q, cmt_valid_d;
  logic [CNT_W-1:0]       cmt_count_q, cmt_count_d;

  logic [NUM_REQS-1:0]    cand;
  logic [NUM_REQS-1:0]    grant;
  logic [NUM_REQS-1:0]    ready;
  logic [NUM_REQS-1:0]    fire;
  logic                   grant_found;
  logic [PTR_W-1:0]       grant_idx;
  logic                   can_load;
  logic                   wb_fire;

  assign cand     = bus.req_valid & bus.req_wb;
  assign can_load = !wb_valid_q || bus.wb_ready;

  // While locked the owner is the only eligible source, even when it idles.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (state_q == ST_LOCKED) begin
      grant_found = cand[lock_src_q];
      grant_idx   = lock_src_q;
    end else begin
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
        if (!grant_found && cand[(32'(rr_ptr_q) + k) % NUM_REQS]) begin
          grant_found = 1'b1;
          grant_idx   = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQS);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    ready = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      grant[i] = grant_found && (32'(grant_idx) == i);
      ready[i] = !bus.req_wb[i] || (grant[i] && can_load);
    end
  end

  assign fire    = bus.req_valid & ready;
  assign wb_fire = grant_found && can_load;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_src_d  = lock_src_q;
    wb_valid_d  = wb_valid_q;
    wb_wid_d    = wb_wid_q;
    wb_tmask_d  = wb_tmask_q;
    wb_pc_d     = wb_pc_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_eop_d    = wb_eop_q;
    if (can_load) begin
      wb_valid_d = 1'b0;
    end
    if (wb_fire) begin
      wb_valid_d = 1'b1;
      wb_wid_d   = bus.req_wid[32'(grant_idx)*NW_BITS +: NW_BITS];
      wb_tmask_d = bus.req_tmask[32'(grant_idx)*NUM_THREADS +: NUM_THREADS];
      wb_pc_d    = bus.req_pc[32'(grant_idx)*32 +: 32];
      wb_rd_d    = bus.req_rd[32'(grant_idx)*NR_BITS +: NR_BITS];
      wb_data_d  = bus.req_data[32'(grant_idx)*DW +: DW];
      wb_eop_d   = bus.req_eop[grant_idx];
      if (bus.req_eop[grant_idx]) begin
        state_d  = ST_OPEN;
        rr_ptr_d = (grant_idx == PTR_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d    = ST_LOCKED;
        lock_src_d = grant_idx;
      end
    end
  end

  // Counts every fire, writing or not, so stores and fences are included.
  always_comb begin
    cmt_valid_d = |fire;
    cmt_count_d = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (fire[i]) begin
        cmt_count_d = cmt_count_d
                    + CNT_W'($countones(bus.req_tmask[i*NUM_THREADS +: NUM_THREADS]));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_OPEN;
      rr_ptr_q    <= '0;
      lock_src_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_wid_q    <= '0;
      wb_tmask_q  <= '0;
      wb_pc_q     <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_eop_q    <= 1'b0;
      cmt_valid_q <= 1'b0;
      cmt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_src_q  <= lock_src_d;
      wb_valid_q  <= wb_valid_d;
      wb_wid_q    <= wb_wid_d;
      wb_tmask_q  <= wb_tmask_d;
      wb_pc_q     <= wb_pc_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_eop_q    <= wb_eop_d;
      cmt_valid_q <= cmt_valid_d;
      cmt_count_q <= cmt_count_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_wid    = wb_wid_q;
  assign bus.wb_tmask  = wb_tmask_q;
  assign bus.wb_pc     = wb_pc_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_eop    = wb_eop_q;
  assign bus.cmt_valid = cmt_valid_q;
  assign bus.cmt_count = cmt_count_q;
endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Directed and randomized bench for vx_writeback_arbiter against a behavioural
// model of round-robin writeback arbitration with packet locking.
module tb_vx_writeback_arbiter;
  localparam int NR  = 7;
  localparam int NT  = 4;
  localparam int NWB = 2;
  localparam int NRB = 5;
  localparam int CW  = $clog2(NR * NT + 1);
  localparam int PW  = NWB + NT + 32 + NRB + NT * 32 + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vx_writeback_arbiter_if #(.NUM_REQS(NR), .NUM_THREADS(NT), .NW_BITS(NWB),
                            .NR_BITS(NRB), .CNT_W(CW)) bus ();

  vx_writeback_arbiter #(.NUM_REQS(NR), .NUM_THREADS(NT), .NW_BITS(NWB),
                         .NR_BITS(NRB), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  int          m_ptr;
  int          m_lock_src;
  bit          m_locked;
  logic        m_wb_valid;
  logic [PW-1:0] m_payload;
  logic        m_cmt_valid;
  int          m_cmt_count;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] src_payload(input int s);
    return {bus.req_wid[s*NWB +: NWB], bus.req_tmask[s*NT +: NT], bus.req_pc[s*32 +: 32],
            bus.req_rd[s*NRB +: NRB], bus.req_data[s*NT*32 +: NT*32], bus.req_eop[s]};
  endfunction

  function automatic logic [PW-1:0] out_payload();
    return {bus.wb_wid, bus.wb_tmask, bus.wb_pc, bus.wb_rd, bus.wb_data, bus.wb_eop};
  endfunction

  task automatic model_reset();
    m_ptr       = 0;
    m_lock_src  = 0;
    m_locked    = 0;
    m_wb_valid  = 1'b0;
    m_payload   = '0;
    m_cmt_valid = 1'b0;
    m_cmt_count = 0;
  endtask

  // Owner of the port this cycle: lock holder, else first writer at or after the pointer.
  function automatic int model_pick();
    if (m_locked) return (bus.req_valid[m_lock_src] && bus.req_wb[m_lock_src]) ? m_lock_src : -1;
    for (int k = 0; k < NR; k++) begin
      int s = (m_ptr + k) % NR;
      if (bus.req_valid[s] && bus.req_wb[s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] model_ready(input int g);
    logic [NR-1:0] r;
    bit can = !m_wb_valid || bus.wb_ready;
    for (int i = 0; i < NR; i++) r[i] = !bus.req_wb[i] || (can && g == i);
    return r;
  endfunction

  task automatic model_commit(input int g, input logic [NR-1:0] rdy);
    bit can = !m_wb_valid || bus.wb_ready;
    int cnt = 0;
    bit any = 0;
    for (int i = 0; i < NR; i++) begin
      if (bus.req_valid[i] && rdy[i]) begin
        any = 1;
        cnt += $countones(bus.req_tmask[i*NT +: NT]);
      end
    end
    m_cmt_valid = any;
    m_cmt_count = cnt;
    if (can) begin
      if (g >= 0) begin
        m_wb_valid = 1'b1;
        m_payload  = src_payload(g);
        if (bus.req_eop[g]) begin
          m_locked = 0;
          m_ptr    = (g + 1) % NR;
        end else begin
          m_locked   = 1;
          m_lock_src = g;
        end
      end else begin
        m_wb_valid = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    int g;
    logic [NR-1:0] er;
    #1;
    g  = model_pick();
    er = model_ready(g);
    chk("req_ready", 256'(bus.req_ready), 256'(er));
    @(posedge clk);
    model_commit(g, er);
    #1;
    chk("wb_valid", 256'(bus.wb_valid), 256'(m_wb_valid));
    if (m_wb_valid) chk("wb_payload", 256'(out_payload()), 256'(m_payload));
    chk("cmt", 256'({bus.cmt_valid, bus.cmt_count}), 256'({m_cmt_valid, CW'(m_cmt_count)}));
    @(negedge clk);
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_wb    = '0;
    bus.req_wid   = '0;
    bus.req_tmask = '0;
    bus.req_pc    = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.req_eop   = '0;
  endtask

  task automatic set_src(input int s, input bit v, input bit wb, input int wid,
                         input logic [NT-1:0] tm, input logic [31:0] pc, input int rd,
                         input bit eop);
    bus.req_valid[s]            = v;
    bus.req_wb[s]               = wb;
    bus.req_wid[s*NWB +: NWB]   = NWB'(wid);
    bus.req_tmask[s*NT +: NT]   = tm;
    bus.req_pc[s*32 +: 32]      = pc;
    bus.req_rd[s*NRB +: NRB]    = NRB'(rd);
    for (int t = 0; t < NT; t++) bus.req_data[(s*NT + t)*32 +: 32] = $urandom;
    bus.req_eop[s]              = eop;
  endtask

  initial begin
    clear_all();
    bus.wb_ready = 1'b1;
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("reset_outs", 256'({bus.wb_valid, out_payload(), bus.cmt_valid, bus.cmt_count}), 256'(0));
    @(negedge clk);
    reset = 1'b0;

    // Single writeback from source 2.
    set_src(2, 1, 1, 1, 4'b1011, 32'h0000_2000, 5, 1);
    cycle();
    chk("tp2_wid", 256'(bus.wb_wid), 256'(1));
    chk("tp2_rd", 256'(bus.wb_rd), 256'(5));
    chk("tp2_cnt", 256'({bus.cmt_valid, bus.cmt_count}), 256'({1'b1, 5'd3}));

    // Sources 0 and 3 compete continuously.
    clear_all();
    for (int n = 0; n < 4; n++) begin
      set_src(0, 1, 1, 0, 4'b1111, 32'h0000_1000 + n, 1, 1);
      set_src(3, 1, 1, 3, 4'b0110, 32'h0000_3000 + n, 2, 1);
      cycle();
    end

    // Back-pressure: writer stalls, store keeps retiring.
    clear_all();
    bus.wb_ready = 1'b0;
    set_src(1, 1, 1, 2, 4'b0011, 32'h0000_1100, 7, 1);
    set_src(4, 1, 0, 0, 4'b1001, 32'h0000_4400, 0, 1);
    for (int n = 0; n < 3; n++) cycle();
    bus.wb_ready = 1'b1;
    cycle();

    // Locked multi-beat packet from source 1, with a gap, while source 0 waits.
    clear_all();
    set_src(0, 1, 1, 0, 4'b0001, 32'h0000_1200, 3, 1);
    cycle();
    set_src(1, 1, 1, 1, 4'b1110, 32'h0000_1300, 9, 0);
    cycle();
    set_src(1, 0, 1, 1, 4'b1110, 32'h0000_1301, 9, 0);
    cycle();
    set_src(1, 1, 1, 1, 4'b1110, 32'h0000_1302, 9, 0);
    cycle();
    set_src(1, 1, 1, 1, 4'b1110, 32'h0000_1303, 9, 1);
    cycle();
    set_src(1, 0, 0, 0, 4'b0000, 32'h0, 0, 0);
    cycle();

    // Store and writeback fire together.
    clear_all();
    set_src(4, 1, 0, 0, 4'b1111, 32'h0000_4000, 0, 1);
    set_src(0, 1, 1, 0, 4'b0001, 32'h0000_0500, 4, 1);
    cycle();
    chk("both_cnt", 256'(bus.cmt_count), 256'(5));

    // Asynchronous reset while a beat is held.
    clear_all();
    set_src(2, 1, 1, 1, 4'b0101, 32'h0000_2200, 6, 1);
    cycle();
    clear_all();
    bus.wb_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_wb_valid", 256'(bus.wb_valid), 256'(0));
    chk("arst_cmt", 256'({bus.cmt_valid, bus.cmt_count}), 256'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.wb_ready = 1'b1;
    set_src(0, 1, 1, 0, 4'b0011, 32'h0000_0A00, 1, 1);
    set_src(3, 1, 1, 2, 4'b1100, 32'h0000_0A03, 2, 1);
    cycle();
    chk("arst_first_grant", 256'(bus.wb_pc), 256'(32'h0000_0A00));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < NR; s++) begin
        set_src(s, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                NT'($urandom), $urandom, $urandom_range(0, 31), $urandom_range(0, 3) != 0);
      end
      bus.wb_ready = $urandom_range(0, 3) != 0;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/vx_writeback_arbiter.md
Name: vx_writeback_arbiter

Overview:
- Arbitrates the per-unit commit streams (ALU, SAU, LD, ST, CSR, FPU, GPU) onto the single register-file writeback port feeding issue.
- Retires non-writing commits (stores, fences) immediately, without consuming the writeback port.
- Produces a registered per-cycle committed-thread count for the CSR unit.
- Sits between the execute units' commit interfaces and the issue/writeback interface of the pipeline.

Parameters:
NUM_REQS, 7, number of commit sources
NUM_THREADS, 4, threads per warp
NW_BITS, 2, warp-id width
NR_BITS, 5, register-index width
CNT_W, $clog2(NUM_REQS*NUM_THREADS+1), width of cmt_count (5 at defaults)

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
req_valid  in  NUM_REQS  commit valid per source
req_wb  in  NUM_REQS  1 = writes register file
req_wid  in  NUM_REQS*NW_BITS  warp id
req_tmask  in  NUM_REQS*NUM_THREADS  thread mask
req_pc  in  NUM_REQS*32  PC
req_rd  in  NUM_REQS*NR_BITS  destination register
req_data  in  NUM_REQS*NUM_THREADS*32  writeback data
req_eop  in  NUM_REQS  last beat of instruction
req_ready  out  NUM_REQS  commit accepted this cycle
wb_valid  out  1  writeback valid (registered)
wb_wid  out  NW_BITS  writeback warp id
wb_tmask  out  NUM_THREADS  writeback thread mask
wb_pc  out  32  writeback PC
wb_rd  out  NR_BITS  writeback register
wb_data  out  NUM_THREADS*32  writeback data
wb_eop  out  1  writeback end of packet
wb_ready  in  1  writeback sink ready
cmt_valid  out  1  at least one commit fired last cycle
cmt_count  out  CNT_W  threads committed last cycle

Behaviour:
- Reset (async):
  - wb_valid=0 and all wb_* = 0.
  - cmt_valid=0, cmt_count=0.
  - RR pointer = 0; lock cleared.
  - Reset mid-transfer discards the held beat.
- Fire definition: fire[i] = req_valid[i] & req_ready[i].
- Non-writing sources: req_ready[i]=1 whenever req_wb[i]=0 (combinational). They retire in the same cycle, independent of the writeback state.
- Writing candidates: req_valid[i] & req_wb[i].
- Output register can load when: !wb_valid | wb_ready.
- Grant: exactly one candidate is granted.
  - Round-robin, searching from the RR pointer upward modulo NUM_REQS.
  - For a writing source, req_ready[i] = grant[i] & can_load.
- Latency: the accepted beat appears on wb_* on the next cycle. wb_valid is cleared by wb_ready when no new beat loads.
- Hold: while wb_valid & !wb_ready, all wb_* stay stable and no writing source is ready.
- Lock:
  - When a granted beat with eop=0 fires, lock onto that source.
  - While locked, only that source may be granted; others wait even if it deasserts valid.
  - Lock clears when the eop=1 beat fires.
- RR pointer update: when an eop=1 beat from source i fires, pointer = (i+1) mod NUM_REQS. Otherwise unchanged.
- Commit counter: registered.
  - cmt_count <= sum over all i with fire[i] of popcount(tmask[i]), covering both writing and non-writing fires.
  - cmt_valid <= |fire.
  - Sum width is CNT_W; it cannot overflow.
- Simultaneous events: one writing beat plus any number of non-writing fires may occur in the same cycle, and all are counted. A load and a drain in the same cycle keep wb_valid=1 with the new beat.
- req_ready never depends on wb_data/tmask contents; no combinational path from wb_ready into grant selection other than via can_load.

Test Plan:
- Async reset while wb_valid=1 -> wb_valid, cmt_valid and cmt_count go to 0 immediately, without a clock edge; first grant after reset goes to source 0.
- Source 2: wb=1, wid=1, tmask=4'b1011, rd=5, eop=1, with wb_ready=1 -> req_ready[2]=1 that cycle; next cycle wb_valid=1, wb_wid=1, wb_rd=5, cmt_valid=1, cmt_count=3.
- Sources 0 and 3 continuously valid with wb=1, eop=1, wb_ready=1 -> wb beats alternate 0,3,0,3.
- wb_ready=0 for 3 cycles with sources 1 (wb=1) and 4 (wb=0) valid -> wb_* stable, req_ready[1]=0, req_ready[4]=1 every cycle; source 1 is accepted in the cycle wb_ready returns to 1.
- Source 1 sends beats eop=0,0,1 while source 0 is also valid -> three consecutive beats from source 1, then source 0; pointer = 2 after the lock releases.
- Same cycle: source 4 store (wb=0, tmask=4'b1111) and source 0 writeback (tmask=4'b0001) -> both fire; next cycle cmt_count=5.
